// File: rtl/pwm_chan.sv
// One PWM channel: a shadow duty that software writes, and an active duty that is only
// replaced at a period start, so a new duty value never cuts into a running period.
module pwm_chan #(
   parameter int unsigned COUNT_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COUNT_BITS-1:0] count,
   input  logic                  wrap_int,
   input  logic                  en,
   input  logic                  wr,
   input  logic [COUNT_BITS:0]   wr_data,
   output logic                  pwm,
   output logic                  pending
);

   localparam int unsigned DUTY_BITS = COUNT_BITS + 1;

   logic [DUTY_BITS-1:0] shadow_q, shadow_d;
   logic [DUTY_BITS-1:0] active_q, active_d;
   logic                 pending_q, pending_d;
   logic                 pwm_q, pwm_d;
   logic                 load;

   always_comb begin
      load     = wrap_int && pending_q;
      shadow_d = wr ? wr_data : shadow_q;
      // The load takes the shadow as it was before this cycle's write.
      active_d = load ? shadow_q : active_q;
      // A write on the load cycle re-arms pending for the following period.
      pending_d = pending_q;
      if (wr) begin
         pending_d = 1'b1;
      end else if (load) begin
         pending_d = 1'b0;
      end
      // The extra duty bit lets a duty of 2^COUNT_BITS or more hold the output high.
      pwm_d = en && ({1'b0, count} < active_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         pwm_q     <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         pwm_q     <= pwm_d;
      end
   end

   assign pwm     = pwm_q;
   assign pending = pending_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels driven from a shared upstream period count; detects period starts
// and decodes duty writes to the addressed channel.
module pwm_bank #(
   parameter int unsigned COUNT_BITS = 8,
   parameter int unsigned CHANNELS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COUNT_BITS-1:0] count,
   input  logic                  en,
   input  logic                  wr_en,
   input  logic [3:0]            wr_chan,
   input  logic [COUNT_BITS:0]   wr_data,
   output logic [CHANNELS-1:0]   pwm,
   output logic                  wrap,
   output logic [CHANNELS-1:0]   pending
);

   localparam logic [4:0] CHAN_LIMIT = 5'(CHANNELS);

   logic [COUNT_BITS-1:0] count_q, count_p;
   logic                  wrap_int, wrap_q;
   logic                  wr_valid;
   logic [CHANNELS-1:0]   wr_sel;

   // Compare against the previous value so a count held at zero yields one pulse only.
   always_comb begin
      wrap_int = (count_q == '0) && (count_p != '0);
   end

   always_comb begin
      wr_valid = wr_en && ({1'b0, wr_chan} < CHAN_LIMIT);
      wr_sel   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_sel[i] = wr_valid && (wr_chan == 4'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         count_p <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count;
         count_p <= count_q;
         wrap_q  <= wrap_int;
      end
   end

   assign wrap = wrap_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      pwm_chan #(
         .COUNT_BITS(COUNT_BITS)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .count   (count_q),
         .wrap_int(wrap_int),
         .en      (en),
         .wr      (wr_sel[i]),
         .wr_data (wr_data),
         .pwm     (pwm[i]),
         .pending (pending[i])
      );
   end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench: each queued record holds the expected high-cycle count per channel and
// the period length for one full period; the monitor checks a record at every wrap pulse.
module tb_pwm_bank;

   typedef struct packed {
      logic [3:0][15:0] hi;
      logic [15:0]      len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       wr_en;
   logic [3:0] wr_chan;
   logic [8:0] wr_data;
   logic [7:0] count;
   logic [3:0] pwm;
   logic       wrap;
   logic [3:0] pending;

   logic [15:0] cnt = '0;
   int          hidden = 0;

   int   checks = 0;
   int   failures = 0;
   int   wrap_seen = 0;
   int   period_idx = 0;
   exp_t sb_q[$];
   logic front_started = 1'b0;
   int   acc_hi[4];
   int   acc_len = 0;

   pwm_bank #(
      .COUNT_BITS(8),
      .CHANNELS  (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .count  (count),
      .en     (en),
      .wr_en  (wr_en),
      .wr_chan(wr_chan),
      .wr_data(wr_data),
      .pwm    (pwm),
      .wrap   (wrap),
      .pending(pending)
   );

   always #5 clk = ~clk;

   // Upstream free-running counter; hidden low bits make count hold for 2^hidden cycles.
   always @(posedge clk) cnt <= cnt + 16'd1;
   assign count = 8'(cnt >> hidden);

   function automatic void check(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (wrap) begin
         wrap_seen++;
         if (front_started) begin
            e = sb_q.pop_front();
            for (int c = 0; c < 4; c++) begin
               check($sformatf("period%0d_ch%0d_high", period_idx, c), acc_hi[c], int'(e.hi[c]));
            end
            check($sformatf("period%0d_len", period_idx), acc_len, int'(e.len));
            period_idx++;
         end
         front_started = (sb_q.size() != 0);
         acc_len = 1;
         for (int c = 0; c < 4; c++) acc_hi[c] = int'(pwm[c]);
      end else begin
         acc_len++;
         for (int c = 0; c < 4; c++) acc_hi[c] += int'(pwm[c]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write(input int ch, input int data);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_chan = 4'(ch);
      wr_data = 9'(data);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic push(input int h0, input int h1, input int h2, input int h3, input int len);
      exp_t e;
      e.hi[0] = 16'(h0);
      e.hi[1] = 16'(h1);
      e.hi[2] = 16'(h2);
      e.hi[3] = 16'(h3);
      e.len   = 16'(len);
      sb_q.push_back(e);
   endtask

   task automatic wait_wraps(input int n, input int limit);
      int target;
      int cyc;
      target = wrap_seen + n;
      cyc    = 0;
      while (wrap_seen < target && cyc < limit) begin
         @(posedge clk);
         cyc++;
      end
      if (wrap_seen < target) check("wrap_arrival", wrap_seen, target);
      @(negedge clk);
   endtask

   initial begin
      int pc;
      int n;
      logic found;

      rst     = 1'b1;
      en      = 1'b1;
      wr_en   = 1'b0;
      wr_chan = '0;
      wr_data = '0;
      tick(4);
      check("reset_pwm", int'(pwm), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_pending", int'(pending), 0);
      rst = 1'b0;
      tick(10);

      // Single duty write, loaded at the next period start.
      write(0, 64);
      check("t1_pending_set", int'(pending), 1);
      push(64, 0, 0, 0, 256);
      wait_wraps(1, 600);
      check("t1_pending_clear", int'(pending), 0);
      wait_wraps(1, 600);

      // Boundary duties: zero, exactly full scale, above full scale, one short of full.
      write(0, 0);
      write(1, 256);
      write(2, 300);
      write(3, 255);
      push(0, 256, 256, 255, 256);
      wait_wraps(2, 1200);

      // Overwrite while pending, then an out-of-range channel.
      write(2, 20);
      write(2, 200);
      write(7, 5);
      check("t3_pending", int'(pending), 4);
      push(0, 256, 200, 255, 256);
      wait_wraps(2, 1200);

      // Write landing exactly on the wrap detect cycle.
      write(1, 100);
      wait_wraps(1, 600);
      check("t4_pending_pre", int'(pending), 0);
      push(0, 100, 200, 255, 256);
      push(0, 10, 200, 255, 256);
      found = 1'b0;
      n = 0;
      while (!found && n < 600) begin
         pc = int'(count);
         @(negedge clk);
         n++;
         if (count == 8'd0 && pc != 0) found = 1'b1;
      end
      check("t4_found_zero", int'(found), 1);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_chan = 4'd1;
      wr_data = 9'd10;
      @(negedge clk);
      wr_en   = 1'b0;
      @(negedge clk);
      check("t4_pending_after_wrap_write", int'(pending), 2);
      tick(200);
      check("t4_pending_held", int'(pending), 2);
      wait_wraps(1, 600);
      check("t4_pending_cleared", int'(pending), 0);
      wait_wraps(1, 600);

      // Reset mid-period with all channels pending and en toggling.
      en = 1'b0;
      write(0, 200);
      en = 1'b1;
      write(1, 200);
      en = 1'b0;
      write(2, 200);
      en = 1'b1;
      write(3, 200);
      check("t5_pending_all", int'(pending), 15);
      rst     = 1'b1;
      wr_en   = 1'b1;
      wr_chan = 4'd0;
      wr_data = 9'd77;
      @(negedge clk);
      check("t5_rst_pwm", int'(pwm), 0);
      check("t5_rst_wrap", int'(wrap), 0);
      check("t5_rst_pending", int'(pending), 0);
      rst   = 1'b0;
      wr_en = 1'b0;
      tick(2);
      check("t5_wr_during_rst", int'(pending), 0);
      push(0, 0, 0, 0, 256);
      wait_wraps(2, 1200);
      en = 1'b0;
      write(0, 128);
      write(1, 128);
      write(2, 128);
      write(3, 128);
      push(0, 0, 0, 0, 256);
      wait_wraps(2, 1200);
      en = 1'b1;
      push(128, 128, 128, 128, 256);
      wait_wraps(2, 1200);

      // Upstream holding each count value for 8 cycles.
      rst    = 1'b1;
      hidden = 3;
      tick(3);
      rst = 1'b0;
      write(0, 128);
      write(1, 256);
      write(2, 0);
      write(3, 1);
      push(1024, 2048, 0, 8, 2048);
      wait_wraps(2, 5000);

      check("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter COUNT_BITS, default 8, width of the shared period count input.
REQ-002 Parameter CHANNELS, default 4, number of PWM outputs (1..16).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 count  input  COUNT_BITS  free-running binary period count from the upstream counter; may hold each value for many cycles.
REQ-006 en  input  1  output enable; 0 forces all pwm bits low.
REQ-007 wr_en  input  1  single-cycle duty write strobe.
REQ-008 wr_chan  input  4  channel index for the write.
REQ-009 wr_data  input  COUNT_BITS+1  new duty value.
REQ-010 pwm  output  CHANNELS  registered PWM outputs.
REQ-011 wrap  output  1  registered one-cycle pulse at each period start.
REQ-012 pending  output  CHANNELS  per-channel flag: a shadow duty is waiting for the next period start.

Function
REQ-013 count shall be registered once (count_q) and also delayed to count_p; wrap_int = (count_q == 0) && (count_p != 0).
REQ-014 wrap shall equal wrap_int delayed so that it is high in the same cycle as the first pwm value of the new period.
REQ-015 Each channel shall hold a shadow duty register and an active duty register, both COUNT_BITS+1 wide.
REQ-016 wr_en with wr_chan < CHANNELS shall load shadow[wr_chan] from wr_data and set pending[wr_chan] on the next edge; wr_chan >= CHANNELS shall be ignored.
REQ-017 On a wrap_int cycle, every channel with pending set before that cycle shall copy shadow to active and clear pending.
REQ-018 A write in the same cycle as wrap_int shall update the shadow only; the load uses the prior shadow, and pending stays 1 for the next period.
REQ-019 A write to a channel that is already pending shall overwrite the shadow; only the last value is loaded.
REQ-020 pwm[i] shall register (count_q < active_next[i]) && en, where active_next[i] is the active value after any same-cycle load.
REQ-021 Duty 0 shall give a constantly low output; duty >= 2^COUNT_BITS shall give a constantly high output; duty d shall give d high steps per 2^COUNT_BITS steps.
REQ-022 Latency from count input to pwm shall be 2 cycles.
REQ-023 Holding count (upstream hidden bits) shall produce exactly one wrap pulse per period.
REQ-024 en shall gate only pwm; duty loads and wrap shall continue while en=0.

Reset
REQ-025 rst shall clear count_q, count_p, every shadow and active duty, pending, pwm and wrap to 0 on the next edge.
REQ-026 rst asserted mid-period shall discard pending writes; the first wrap after release needs count to leave 0 and return to 0.
REQ-027 wr_en during rst shall be ignored.

Structure
REQ-028 No shared package is needed; DUTY_BITS = COUNT_BITS+1 shall be a local constant.
REQ-029 The per-channel shadow, active and pending registers and the compare shall live in one sub-module, pwm_chan, instantiated CHANNELS times.
REQ-030 The count register, wrap detect and write decode shall live in pwm_bank.

Verification (COUNT_BITS=8, CHANNELS=4, count driven by an 8-bit counter with 0 hidden bits)
REQ-031 Write ch0 duty 64, then run 2 periods -> from the second wrap, pwm[0] is high for exactly 64 of every 256 cycles, and pending[0] clears at the wrap.
REQ-032 Duties 0, 256, 300 and 255 on ch0..3 -> pwm[0] always 0, pwm[1] and pwm[2] always 1, pwm[3] low for exactly 1 cycle per period.
REQ-033 Write ch1=10 on the exact wrap_int cycle -> the current period keeps the old duty, pending[1]=1 for 256 cycles, and the new duty applies from the next wrap.
REQ-034 Write ch2=20, then ch2=200, in one period -> only 200 is applied; wr_chan=7 -> no state change.
REQ-035 Upstream with HIDDEN_BITS=3 (count holds 8 cycles per value) -> one wrap per 2048 cycles; duty 128 gives 1024 high cycles.
REQ-036 rst mid-period with pending=4'b1111 and en toggling -> all outputs 0 after 1 edge; pwm stays 0 while en=0 but wrap still pulses.
